// File: rtl/run_seq_if.sv
// Control, status and datapath start/done handshake of the run sequencer.
// The master modport is the sequencer's view. The slave modport is the view of the config block and datapath.
interface run_seq_if #(
    parameter int DLY_W = 16,
    parameter int CNT_W = 8
);
    logic             cfg_done;
    logic             arm;
    logic             abort;
    logic [DLY_W-1:0] start_dly;
    logic [CNT_W-1:0] run_cnt;
    logic             dp_start;
    logic             dp_done;
    logic             busy;
    logic             seq_done;
    logic [CNT_W-1:0] runs_done;
    logic             err_timeout;

    modport master (
        input  cfg_done, arm, abort, start_dly, run_cnt, dp_done,
        output dp_start, busy, seq_done, runs_done, err_timeout
    );

    modport slave (
        output cfg_done, arm, abort, start_dly, run_cnt, dp_done,
        input  dp_start, busy, seq_done, runs_done, err_timeout
    );
endinterface

// File: rtl/run_sequencer.sv
// Waits for configuration, then issues delayed datapath start pulses for run_cnt runs.
// Optional RUN-state timeout is enabled by defining RUN_SEQ_TIMEOUT_EN.
module run_sequencer #(
    parameter int DLY_W     = 16,
    parameter int CNT_W     = 8,
    parameter int TO_W      = 24,
    parameter int TO_CYCLES = 1_000_000
) (
    input  logic      clk,
    input  logic      rst,
    run_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CFG, S_DELAY, S_START, S_RUN, S_FINISH
    } state_t;

    state_t           state_reg, state_next;
    logic [DLY_W-1:0] dly_reg, dly_next;
    logic [DLY_W-1:0] dly_cnt_reg, dly_cnt_next;
    logic [CNT_W-1:0] tgt_reg, tgt_next;
    logic [CNT_W-1:0] runs_reg, runs_next;
    logic [CNT_W-1:0] runs_inc;

    assign runs_inc = runs_reg + CNT_W'(1);

`ifdef RUN_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            err_reg, err_next;
    logic            to_hit;

    // to_cnt counts cycles since dp_start. seq_done therefore lands TO_CYCLES after the pulse.
    assign to_hit = (to_cnt_reg == TO_W'(TO_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            dly_reg     <= '0;
            dly_cnt_reg <= '0;
            tgt_reg     <= '0;
            runs_reg    <= '0;
`ifdef RUN_SEQ_TIMEOUT_EN
            to_cnt_reg  <= '0;
            err_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            dly_reg     <= dly_next;
            dly_cnt_reg <= dly_cnt_next;
            tgt_reg     <= tgt_next;
            runs_reg    <= runs_next;
`ifdef RUN_SEQ_TIMEOUT_EN
            to_cnt_reg  <= to_cnt_next;
            err_reg     <= err_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        dly_next     = dly_reg;
        dly_cnt_next = dly_cnt_reg;
        tgt_next     = tgt_reg;
        runs_next    = runs_reg;
`ifdef RUN_SEQ_TIMEOUT_EN
        to_cnt_next  = '0;
        err_next     = err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (bus.arm) begin
                    state_next = S_WAIT_CFG;
                    dly_next   = bus.start_dly;
                    tgt_next   = (bus.run_cnt == '0) ? CNT_W'(1) : bus.run_cnt;
                    runs_next  = '0;
`ifdef RUN_SEQ_TIMEOUT_EN
                    err_next   = 1'b0;
`endif
                end
            end
            S_WAIT_CFG: begin
                if (bus.cfg_done) begin
                    dly_cnt_next = dly_reg;
                    state_next   = (dly_reg == '0) ? S_START : S_DELAY;
                end
            end
            S_DELAY: begin
                if (dly_cnt_reg <= DLY_W'(1))
                    state_next = S_START;
                else
                    dly_cnt_next = dly_cnt_reg - DLY_W'(1);
            end
            S_START: begin
                state_next = S_RUN;
`ifdef RUN_SEQ_TIMEOUT_EN
                to_cnt_next = TO_W'(1);
`endif
            end
            S_RUN: begin
`ifdef RUN_SEQ_TIMEOUT_EN
                to_cnt_next = to_cnt_reg + TO_W'(1);
`endif
                // dp_done is checked before the timeout, so a done in the timeout cycle still counts.
                if (bus.dp_done) begin
                    runs_next = runs_inc;
                    if (runs_inc == tgt_reg) begin
                        state_next = S_FINISH;
                    end else begin
                        dly_cnt_next = dly_reg;
                        state_next   = (dly_reg == '0) ? S_START : S_DELAY;
                    end
                end
`ifdef RUN_SEQ_TIMEOUT_EN
                else if (to_hit) begin
                    err_next   = 1'b1;
                    state_next = S_FINISH;
                end
`endif
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase

        if (bus.abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            runs_next  = runs_reg;
`ifdef RUN_SEQ_TIMEOUT_EN
            err_next   = err_reg;
`endif
        end
    end

    // An abort suppresses the pulse of the current cycle as well as the following state.
    assign bus.dp_start  = (state_reg == S_START)  && !bus.abort;
    assign bus.seq_done  = (state_reg == S_FINISH) && !bus.abort;
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.runs_done = runs_reg;
`ifdef RUN_SEQ_TIMEOUT_EN
    assign bus.err_timeout = err_reg;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: table-driven full sequences plus abort, reset and timeout cases.
// Outputs are sampled on the falling edge. Sample 0 is the cycle in which arm is held high.
`timescale 1ns/1ps
module tb_run_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    run_seq_if #(.DLY_W(16), .CNT_W(8)) bus ();

    run_sequencer #(.DLY_W(16), .CNT_W(8), .TO_W(24), .TO_CYCLES(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int dly;
        int cnt;
        int cfg_wait;
        int lat;
        bit rearm;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic arm_seq(input int dly, input int cnt);
        @(negedge clk);
        bus.start_dly = 16'(dly);
        bus.run_cnt   = 8'(cnt);
        bus.cfg_done  = 1'b1;
        bus.arm       = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    // Expected start/done times are derived from the latency rules:
    // first start at max(cfg_wait,1)+1+dly, and each later start at done+1+dly.
    task automatic run_vec(input int idx, input vec_t v);
        int  tgt, s, exp_start, exp_seq, done_at, starts;
        bit  seen;
        tgt       = (v.cnt == 0) ? 1 : v.cnt;
        exp_start = ((v.cfg_wait == 0) ? 1 : v.cfg_wait) + 1 + v.dly;
        exp_seq   = -1;
        done_at   = -1;
        starts    = 0;
        seen      = 1'b0;
        s         = 0;
        @(negedge clk);
        bus.start_dly = 16'(v.dly);
        bus.run_cnt   = 8'(v.cnt);
        bus.cfg_done  = (v.cfg_wait == 0);
        bus.arm       = 1'b1;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            s++;
            bus.arm     = 1'b0;
            bus.dp_done = 1'b0;
            if (s == v.cfg_wait) bus.cfg_done = 1'b1;
            if (v.rearm && s == 3) begin
                bus.start_dly = 16'd9;
                bus.run_cnt   = 8'd1;
                bus.arm       = 1'b1;
            end
            if (bus.dp_start || s == exp_start) begin
                chk($sformatf("v%0d_dp_start_sample", idx), bus.dp_start ? s : -1, exp_start);
                if (bus.dp_start) begin
                    starts++;
                    done_at = s + v.lat;
                end
                exp_start = -1;
            end
            if (s == done_at) begin
                bus.dp_done = 1'b1;
                if (starts == tgt) exp_seq = s + 1;
                else               exp_start = s + 1 + v.dly;
            end
            if (bus.seq_done || s == exp_seq) begin
                chk($sformatf("v%0d_seq_done_sample", idx), bus.seq_done ? s : -1, exp_seq);
                seen = 1'b1;
            end
        end
        chk($sformatf("v%0d_seq_done_seen", idx), int'(seen), 1);
        chk($sformatf("v%0d_start_count", idx), starts, tgt);
        chk($sformatf("v%0d_runs_done", idx), int'(bus.runs_done), tgt);
        step();
        chk($sformatf("v%0d_busy_after", idx), int'(bus.busy), 0);
        chk($sformatf("v%0d_err_timeout", idx), int'(bus.err_timeout), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{dly: 0, cnt: 1, cfg_wait: 0,  lat: 3, rearm: 1'b0};
        vecs[1] = '{dly: 3, cnt: 3, cfg_wait: 10, lat: 2, rearm: 1'b0};
        vecs[2] = '{dly: 2, cnt: 0, cfg_wait: 0,  lat: 1, rearm: 1'b0};
        vecs[3] = '{dly: 4, cnt: 2, cfg_wait: 0,  lat: 5, rearm: 1'b1};
        vecs[4] = '{dly: 0, cnt: 3, cfg_wait: 0,  lat: 1, rearm: 1'b0};

        bus.cfg_done  = 1'b1;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.dp_done   = 1'b0;
        bus.start_dly = '0;
        bus.run_cnt   = '0;
        repeat (5) step();
        chk("reset_dp_start", int'(bus.dp_start), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_seq_done", int'(bus.seq_done), 0);
        chk("reset_err_timeout", int'(bus.err_timeout), 0);
        chk("reset_runs_done", int'(bus.runs_done), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Abort in the DELAY of run 2: back to IDLE next cycle, run count held.
        arm_seq(4, 4);
        repeat (5) step();
        chk("abort_delay_start1", int'(bus.dp_start), 1);
        repeat (2) step();
        bus.dp_done = 1'b1;
        step();
        bus.dp_done = 1'b0;
        chk("abort_delay_runs_before", int'(bus.runs_done), 1);
        step();
        bus.abort = 1'b1;
        chk("abort_delay_seq_done", int'(bus.seq_done), 0);
        step();
        bus.abort = 1'b0;
        chk("abort_delay_busy", int'(bus.busy), 0);
        chk("abort_delay_runs", int'(bus.runs_done), 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.dp_start || bus.seq_done) n++;
            step();
        end
        chk("abort_delay_quiet", n, 0);

        // Abort coincident with dp_done: the run is not counted.
        arm_seq(0, 2);
        step();
        chk("abort_done_start", int'(bus.dp_start), 1);
        step();
        step();
        bus.dp_done = 1'b1;
        bus.abort   = 1'b1;
        step();
        bus.dp_done = 1'b0;
        bus.abort   = 1'b0;
        chk("abort_done_busy", int'(bus.busy), 0);
        chk("abort_done_runs", int'(bus.runs_done), 0);

        // Abort in the START cycle suppresses the pulse itself.
        arm_seq(0, 1);
        step();
        bus.abort = 1'b1;
        #1;
        chk("abort_start_gate", int'(bus.dp_start), 0);
        step();
        bus.abort = 1'b0;
        chk("abort_start_busy", int'(bus.busy), 0);

        // dp_done during START is ignored. A dp_done in RUN then completes the run.
        arm_seq(0, 1);
        step();
        bus.dp_done = 1'b1;
        step();
        bus.dp_done = 1'b0;
        chk("start_done_ignored_runs", int'(bus.runs_done), 0);
        chk("start_done_ignored_busy", int'(bus.busy), 1);
        bus.dp_done = 1'b1;
        step();
        bus.dp_done = 1'b0;
        chk("start_done_seq_done", int'(bus.seq_done), 1);
        chk("start_done_runs", int'(bus.runs_done), 1);
        step();

        // Reset in the middle of a sequence.
        arm_seq(2, 3);
        repeat (3) step();
        chk("rst_mid_start", int'(bus.dp_start), 1);
        rst = 1'b1;
        step();
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_dp_start", int'(bus.dp_start), 0);
        chk("rst_mid_runs", int'(bus.runs_done), 0);
        rst = 1'b0;
        step();

`ifdef RUN_SEQ_TIMEOUT_EN
        arm_seq(0, 2);
        step();
        chk("to_start", int'(bus.dp_start), 1);
        repeat (49) step();
        chk("to_err_before", int'(bus.err_timeout), 0);
        chk("to_seq_before", int'(bus.seq_done), 0);
        step();
        chk("to_seq_done", int'(bus.seq_done), 1);
        chk("to_err", int'(bus.err_timeout), 1);
        chk("to_runs", int'(bus.runs_done), 0);
        step();
        chk("to_busy_after", int'(bus.busy), 0);
        chk("to_err_sticky", int'(bus.err_timeout), 1);
        arm_seq(0, 1);
        chk("to_err_cleared", int'(bus.err_timeout), 0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
`else
        arm_seq(0, 1);
        step();
        n = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.seq_done) n++;
        end
        chk("no_to_seq_pulses", n, 0);
        chk("no_to_busy", int'(bus.busy), 1);
        chk("no_to_err", int'(bus.err_timeout), 0);
        bus.dp_done = 1'b1;
        step();
        bus.dp_done = 1'b0;
        chk("no_to_seq_done", int'(bus.seq_done), 1);
        step();
        chk("no_to_busy_after", int'(bus.busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
